frame_check: RTL and testbench

- Downstream consumer of the FIFO byte-reader stage.
- On a `start` request, it drives the reader's `fs`/`fd` handshake and captures the 96-bit frame the reader assembles (12 bytes, byte 0 at `res[0:7]`).
- It then walks the frame one byte per cycle to validate the header and additive checksum.
- It presents either the decoded command/payload with a one-cycle valid pulse, or an error code, to the control logic above.

---
 rtl/frame_check.sv | 175 +++++++++++++++++
 tb/tb_frame_check.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_check.sv
// frame_check: requests one 12-byte frame from the reader stage and latches it.
// It then checks the two header bytes and the additive checksum one byte per
// cycle, and reports either the decoded command/payload or an error code.
module frame_check #(
    parameter logic [7:0]  HEAD0   = 8'h55,
    parameter logic [7:0]  HEAD1   = 8'hAA,
    parameter logic [15:0] TIMEOUT = 16'd1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        fs,
    input  logic        fd,
    input  logic [0:95] res,
    output logic        busy,
    output logic [7:0]  cmd,
    output logic [63:0] payload,
    output logic        data_vld,
    output logic        frm_err,
    output logic [1:0]  err_code,
    output logic [15:0] frm_cnt,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        REL,
        CHECK,
        OUT
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_HEADER  = 2'd1;
    localparam logic [1:0] ERR_CHKSUM  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    state_t      state;
    state_t      state_next;

    logic [0:95] frame_buf;
    logic [3:0]  idx;
    logic [7:0]  sum;
    logic        hdr_fail;
    logic [15:0] tmo_cnt;

    logic [7:0]  cur_byte;
    logic [7:0]  chk_byte;
    logic [7:0]  sum_next;
    logic        hdr_fail_next;
    logic [15:0] tmo_next;
    logic        timed_out;
    logic        last_byte;
    logic        frame_ok;
    logic [7:0]  err_cnt_inc;

    // Select the frame byte addressed by the walk index (byte 0 sits at frame_buf[0:7]).
    always_comb begin
        cur_byte = '0;
        for (int k = 0; k < 12; k++) begin
            if (idx == k[3:0]) begin
                cur_byte = frame_buf[8*k +: 8];
            end
        end
    end

    // Derived checking terms: running sum, sticky header flag, timeout and error-count increment.
    always_comb begin
        chk_byte      = frame_buf[88:95];
        sum_next      = sum + cur_byte;
        hdr_fail_next = hdr_fail
                      | ((idx == 4'd0) && (cur_byte != HEAD0))
                      | ((idx == 4'd1) && (cur_byte != HEAD1));
        tmo_next      = tmo_cnt + 16'd1;
        timed_out     = (tmo_next == TIMEOUT);
        last_byte     = (idx == 4'd10);
        frame_ok      = !hdr_fail_next && (sum_next == chk_byte);
        err_cnt_inc   = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; fd wins over timeout in REQ, and REL waits for the reader to release fd.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = REQ;
            REQ: begin
                if (fd) begin
                    state_next = REL;
                end else if (timed_out) begin
                    state_next = OUT;
                end
            end
            REL:     if (!fd) state_next = CHECK;
            CHECK:   if (last_byte) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and result strobes decoded from the registered state; err_code tells pass from fail in OUT.
    always_comb begin
        fs       = (state == REQ);
        busy     = (state != IDLE);
        data_vld = (state == OUT) && (err_code == ERR_NONE);
        frm_err  = (state == OUT) && (err_code != ERR_NONE);
    end

    // Datapath: frame capture, byte walk, and result registers written on the edge that enters OUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_buf <= '0;
            idx       <= '0;
            sum       <= '0;
            hdr_fail  <= 1'b0;
            tmo_cnt   <= '0;
            cmd       <= '0;
            payload   <= '0;
            err_code  <= ERR_NONE;
            frm_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tmo_cnt <= '0;
                    end
                end
                REQ: begin
                    tmo_cnt <= tmo_next;
                    if (fd) begin
                        frame_buf <= res;
                    end else if (timed_out) begin
                        err_code <= ERR_TIMEOUT;
                        err_cnt  <= err_cnt_inc;
                    end
                end
                REL: begin
                    if (!fd) begin
                        idx      <= '0;
                        sum      <= '0;
                        hdr_fail <= 1'b0;
                    end
                end
                CHECK: begin
                    sum      <= sum_next;
                    hdr_fail <= hdr_fail_next;
                    idx      <= idx + 4'd1;
                    if (last_byte) begin
                        if (frame_ok) begin
                            cmd      <= frame_buf[16:23];
                            payload  <= frame_buf[24:87];
                            err_code <= ERR_NONE;
                            frm_cnt  <= frm_cnt + 16'd1;
                        end else begin
                            err_code <= hdr_fail_next ? ERR_HEADER : ERR_CHKSUM;
                            err_cnt  <= err_cnt_inc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_check.sv
// tb_frame_check: directed bench for frame_check with hand-computed expectations.
// Inputs are driven and outputs sampled just after the falling clock edge.
module tb_frame_check;

    logic        clk;
    logic        rst;
    logic        start;
    logic        fs;
    logic        fd;
    logic [0:95] res;
    logic        busy;
    logic [7:0]  cmd;
    logic [63:0] payload;
    logic        data_vld;
    logic        frm_err;
    logic [1:0]  err_code;
    logic [15:0] frm_cnt;
    logic [7:0]  err_cnt;

    int checks;
    int passes;

    frame_check #(
        .HEAD0  (8'h55),
        .HEAD1  (8'hAA),
        .TIMEOUT(16'd16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .fs      (fs),
        .fd      (fd),
        .res     (res),
        .busy    (busy),
        .cmd     (cmd),
        .payload (payload),
        .data_vld(data_vld),
        .frm_err (frm_err),
        .err_code(err_code),
        .frm_cnt (frm_cnt),
        .err_cnt (err_cnt)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // From IDLE at a falling edge: request a frame, answer fd on the first REQ cycle,
    // release fd once fs drops, and return at the falling edge inside OUT.
    task automatic apply_stimulus(input logic [0:95] f);
        start = 1'b1;
        tick();
        start = 1'b0;
        res   = f;
        fd    = 1'b1;
        tick();
        fd    = 1'b0;
        res   = ~f;
        repeat (12) tick();
    endtask

    // Stimulus and checks as one directed sequence.
    initial begin
        logic [0:95] good;
        logic [0:95] good2;
        logic [0:95] bad_ck;
        logic [0:95] bad_hd;
        int          fs_high;
        logic        seen;

        good   = {8'h55, 8'hAA, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        good2  = {8'h55, 8'hAA, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h65};
        bad_ck = {8'h55, 8'hAA, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h65};
        bad_hd = {8'h54, 8'hAA, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};

        checks = 0;
        passes = 0;
        rst    = 1'b0;
        start  = 1'b0;
        fd     = 1'b0;
        res    = '0;

        // Reset state
        tick();
        check_output("rst_fs", fs, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_data_vld", data_vld, 0);
        check_output("rst_frm_err", frm_err, 0);
        tick();
        rst = 1'b1;
        tick();
        check_output("rst_err_code", err_code, 0);
        check_output("rst_frm_cnt", frm_cnt, 0);
        check_output("rst_err_cnt", err_cnt, 0);
        check_output("rst_cmd", cmd, 0);
        check_output("rst_payload", payload, 0);

        // fd while IDLE is ignored
        fd  = 1'b1;
        res = good;
        tick();
        tick();
        check_output("fd_in_idle_busy", busy, 0);
        fd = 1'b0;
        tick();

        // Good frame with latency check
        start = 1'b1;
        tick();
        check_output("start_to_fs", fs, 1);
        start = 1'b0;
        res   = good;
        fd    = 1'b1;
        tick();
        check_output("fs_low_in_rel", fs, 0);
        check_output("busy_in_rel", busy, 1);
        fd   = 1'b0;
        res  = ~good;
        seen = 1'b0;
        repeat (11) begin
            tick();
            if (data_vld || frm_err) seen = 1'b1;
        end
        check_output("no_early_pulse", seen, 0);
        tick();
        check_output("good_data_vld", data_vld, 1);
        check_output("good_frm_err", frm_err, 0);
        check_output("good_cmd", cmd, 8'h01);
        check_output("good_payload", payload, 64'h1122334455667788);
        check_output("good_err_code", err_code, 0);
        check_output("good_frm_cnt", frm_cnt, 1);
        tick();
        check_output("good_vld_one_cycle", data_vld, 0);
        check_output("good_idle_busy", busy, 0);

        // Bad checksum
        apply_stimulus(bad_ck);
        check_output("ck_frm_err", frm_err, 1);
        check_output("ck_data_vld", data_vld, 0);
        check_output("ck_err_code", err_code, 2);
        check_output("ck_err_cnt", err_cnt, 1);
        check_output("ck_cmd_kept", cmd, 8'h01);
        check_output("ck_payload_kept", payload, 64'h1122334455667788);
        check_output("ck_frm_cnt", frm_cnt, 1);
        tick();
        check_output("ck_err_one_cycle", frm_err, 0);

        // Bad header (checksum also wrong; header wins)
        apply_stimulus(bad_hd);
        check_output("hd_frm_err", frm_err, 1);
        check_output("hd_err_code", err_code, 1);
        check_output("hd_frm_cnt", frm_cnt, 1);
        check_output("hd_err_cnt", err_cnt, 2);
        tick();

        // Timeout with fd held low
        start = 1'b1;
        tick();
        start   = 1'b0;
        fs_high = 0;
        repeat (16) begin
            if (fs) fs_high++;
            tick();
        end
        check_output("to_fs_cycles", fs_high, 16);
        check_output("to_frm_err", frm_err, 1);
        check_output("to_err_code", err_code, 3);
        check_output("to_fs_low", fs, 0);
        check_output("to_err_cnt", err_cnt, 3);
        tick();
        check_output("to_busy_after", busy, 0);

        // fd on the 16th REQ edge beats the timeout
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        check_output("late_fd_still_req", fs, 1);
        res = good2;
        fd  = 1'b1;
        tick();
        check_output("late_fd_no_err", frm_err, 0);
        check_output("late_fd_busy", busy, 1);
        fd  = 1'b0;
        res = '0;
        repeat (12) tick();
        check_output("late_fd_data_vld", data_vld, 1);
        check_output("late_fd_cmd", cmd, 8'h02);
        check_output("late_fd_err_code", err_code, 0);
        check_output("late_fd_frm_cnt", frm_cnt, 2);
        tick();

        // start held high across a whole transaction
        start = 1'b1;
        tick();
        res = good;
        fd  = 1'b1;
        tick();
        fd = 1'b0;
        repeat (11) tick();
        check_output("held_start_no_fs_in_check", fs, 0);
        tick();
        check_output("held_start_data_vld", data_vld, 1);
        check_output("held_start_frm_cnt", frm_cnt, 3);
        tick();
        check_output("held_start_idle_busy", busy, 0);
        check_output("held_start_idle_fs", fs, 0);
        tick();
        check_output("held_start_restart_fs", fs, 1);
        start = 1'b0;
        res   = good;
        fd    = 1'b1;
        tick();
        fd = 1'b0;
        repeat (12) tick();
        check_output("held_start_second_vld", data_vld, 1);
        check_output("held_start_second_cnt", frm_cnt, 4);
        tick();

        // Reset at CHECK index 5
        start = 1'b1;
        tick();
        start = 1'b0;
        res   = good;
        fd    = 1'b1;
        tick();
        fd = 1'b0;
        repeat (6) tick();
        rst = 1'b0;
        #1;
        check_output("midrst_fs", fs, 0);
        check_output("midrst_busy", busy, 0);
        check_output("midrst_frm_cnt", frm_cnt, 0);
        check_output("midrst_err_cnt", err_cnt, 0);
        check_output("midrst_data_vld", data_vld, 0);
        check_output("midrst_frm_err", frm_err, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_output("midrst_after_busy", busy, 0);
        apply_stimulus(good);
        check_output("midrst_good_vld", data_vld, 1);
        check_output("midrst_good_cmd", cmd, 8'h01);
        check_output("midrst_good_frm_cnt", frm_cnt, 1);
        tick();

        // 256 bad frames: err_cnt saturates at FF
        for (int i = 0; i < 256; i++) begin
            apply_stimulus(bad_ck);
            if (i == 253) check_output("sat_err_cnt_fe", err_cnt, 8'hFE);
            if (i == 254) check_output("sat_err_cnt_ff", err_cnt, 8'hFF);
            if (i == 255) begin
                check_output("sat_err_cnt_hold", err_cnt, 8'hFF);
                check_output("sat_frm_err", frm_err, 1);
            end
            tick();
        end
        check_output("sat_frm_cnt_kept", frm_cnt, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
